vga_csr_bank: RTL and testbench
===============================

# vga_csr_bank

Native-side control/status register bank for the VGA core, directly downstream of `vga_axil_slave_fsm`. It consumes that FSM's native write strobe, write address and write data, and its synchronous read strobe and read address. It returns registered read data one cycle after each read strobe. It holds the VGA control state (enable, background colour, IRQ enable), a frame counter and a frame-done interrupt with write-1-to-clear semantics.

## Interface
- `ADDR_W`, 4: native word-address width; must match the FSM's native address width.
- `DATA_W`, 32: data width; equals the AXI-Lite data width.
- `clk_i` in 1: system clock, rising-edge.
- `arst_i` in 1: reset; asynchronous, active-high.
- `write_en_i` in 1: native write strobe, one cycle per write (FSM `write_en_o`).
- `addr_write_i` in `ADDR_W`: word address of the write (FSM `addr_write_o`).
- `wdata_i` in `DATA_W`: write data (FSM `data_o`).
- `read_en_i` in 1: synchronous read strobe (FSM `read_en_sync_o`).
- `addr_read_i` in `ADDR_W`: word address of the read (FSM `addr_read_o`).
- `rdata_o` out `DATA_W`: registered read data (FSM `data_i`).
- `frame_done_i` in 1: single-cycle pulse from the timing generator at the end of each frame.
- `enable_o` out 1: `CTRL[0]`.
- `bg_color_o` out 12: `BG_COLOR[11:0]`, RGB444.
- `irq_o` out 1: `CTRL[1] & IRQ[0]`, registered.

## Operation
Register map (word addresses):
- 0x0 `CTRL`, RW: `[0]` enable, `[1]` irq_en, all other bits read 0.
- 0x1 `STATUS`, RO: `[0]` = `IRQ[0]`, `[1]` = `CTRL[0]`. Writes ignored.
- 0x2 `IRQ`, W1C: `[0]` frame-done pending. Writing 1 to bit 0 clears it; writing 0 has no effect.
- 0x3 `FRAME_CNT`, RO: 32-bit counter, +1 on each `frame_done_i` while `CTRL[0]`=1. Wraps 0xFFFF_FFFF→0. Writes ignored.
- 0x4 `BG_COLOR`, RW: `[11:0]`, upper bits read 0.
- 0x5 `SCRATCH`, RW: full 32 bits.
- 0x6..max: unmapped. Reads return 0; writes ignored. No error response is generated.

Rules:
- The pending bit sets on `frame_done_i` only when `CTRL[0]`=1.
- Set has priority over clear: a W1C write to `IRQ` in the same cycle as a qualifying `frame_done_i` leaves pending=1.
- Read and write in the same cycle, same address: the read returns the pre-write value.
- Read of `FRAME_CNT` in the same cycle as an increment returns the pre-increment value.
- Clearing `CTRL[0]` freezes `FRAME_CNT` without resetting it. It does not clear an already-pending IRQ.

## Timing
- Reset values, all asynchronous on `arst_i`=1:
  - `CTRL`, `IRQ`, `FRAME_CNT`, `BG_COLOR`, `SCRATCH` = 0.
  - `rdata_o`=0, `enable_o`=0, `bg_color_o`=0, `irq_o`=0.
- Write: register updates at the edge where `write_en_i`=1. `enable_o`/`bg_color_o` reflect it from that edge.
- Read: `read_en_i`=1 at edge N → `rdata_o` valid after edge N, i.e. 1-cycle latency.
  - `rdata_o` holds its value until the next read strobe.
  - Back-to-back reads on consecutive cycles are each answered one cycle later.
- `irq_o`:
  - Asserts one edge after the pending bit sets (registered AND).
  - Deasserts one edge after the pending bit clears or `irq_en` falls.
- Reset mid-operation: all state returns to reset values immediately. A read strobe in the reset cycle produces no data, and `rdata_o`=0 after release.

## Configuration
- `VGA_CSR_FRAME_CNT_EN` defined: the `FRAME_CNT` register and its 32-bit counter are implemented as above.
- Undefined: no counter flops are generated. Address 0x3 behaves as unmapped (reads 0, writes ignored). IRQ pending and `irq_o` behaviour is unchanged.

## Test plan
- Reset: hold `arst_i`=1, then release → all outputs 0. Read 0x0..0x5 → each returns 0.
- RW registers:
  - Write `CTRL`=0xFFFF_FFFF → read returns 0x3, and `enable_o`=1.
  - Write `BG_COLOR`=0xABCD_E123 → read returns 0x123, and `bg_color_o`=0x123.
  - Write `SCRATCH`=0xDEAD_BEEF → read returns 0xDEAD_BEEF.
- Frame counting/IRQ:
  - With `CTRL`=0x3, issue 5 `frame_done_i` pulses → `FRAME_CNT`=5, `STATUS`=0x3, and `irq_o`=1 one cycle after the first pulse.
  - Write `IRQ`=0x1 → `irq_o`=0 next cycle.
- Simultaneous set/clear: W1C write to `IRQ` in the same cycle as `frame_done_i` with `CTRL`=0x1 → `IRQ` reads 0x1.
- Same-cycle read/write of `SCRATCH`:
  - Old value 0x1, write 0x2 → `rdata_o`=0x1.
  - Next read → 0x2.
- Unmapped/disabled:
  - Write 0x1234 to 0x7 → read 0x7 returns 0.
  - With `CTRL`=0, pulse `frame_done_i` 3× → `FRAME_CNT` unchanged and `irq_o`=0.
  - Without `VGA_CSR_FRAME_CNT_EN`, read 0x3 → 0.

Source files
------------

// File: rtl/vga_csr_bank.sv
// vga_csr_bank: native-side CSR bank for the VGA core (control, status, W1C frame IRQ, frame counter).
// Define VGA_CSR_FRAME_CNT_EN to build the FRAME_CNT register; otherwise address 0x3 is unmapped.
module vga_csr_bank #(
    parameter int ADDR_W = 4,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              arst_i,
    input  logic              write_en_i,
    input  logic [ADDR_W-1:0] addr_write_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              read_en_i,
    input  logic [ADDR_W-1:0] addr_read_i,
    output logic [DATA_W-1:0] rdata_o,
    input  logic              frame_done_i,
    output logic              enable_o,
    output logic [11:0]       bg_color_o,
    output logic              irq_o
);
    logic [1:0]        ctrl;
    logic              pending;
    logic [11:0]       bg_color;
    logic [DATA_W-1:0] scratch;
    logic [DATA_W-1:0] rd_val;
    logic              frame_hit;

    assign frame_hit  = frame_done_i & ctrl[0];
    assign enable_o   = ctrl[0];
    assign bg_color_o = bg_color;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            ctrl     <= '0;
            pending  <= 1'b0;
            bg_color <= '0;
            scratch  <= '0;
            irq_o    <= 1'b0;
            rdata_o  <= '0;
        end else begin
            if (write_en_i && addr_write_i == ADDR_W'(0)) ctrl <= wdata_i[1:0];
            if (write_en_i && addr_write_i == ADDR_W'(4)) bg_color <= wdata_i[11:0];
            if (write_en_i && addr_write_i == ADDR_W'(5)) scratch <= wdata_i;
            // set wins over a simultaneous W1C
            pending <= frame_hit | (pending & ~(write_en_i && addr_write_i == ADDR_W'(2) && wdata_i[0]));
            irq_o   <= ctrl[1] & pending;
            if (read_en_i) rdata_o <= rd_val;
        end
    end

`ifdef VGA_CSR_FRAME_CNT_EN
    logic [31:0] frame_cnt;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) frame_cnt <= '0;
        else if (frame_hit) frame_cnt <= frame_cnt + 32'd1;
    end
`endif

    always_comb begin
        rd_val = '0;
        case (addr_read_i)
            ADDR_W'(0): rd_val = DATA_W'(ctrl);
            ADDR_W'(1): rd_val = DATA_W'({ctrl[0], pending});
            ADDR_W'(2): rd_val = DATA_W'(pending);
`ifdef VGA_CSR_FRAME_CNT_EN
            ADDR_W'(3): rd_val = DATA_W'(frame_cnt);
`endif
            ADDR_W'(4): rd_val = DATA_W'(bg_color);
            ADDR_W'(5): rd_val = scratch;
            default:    rd_val = '0;
        endcase
    end
endmodule

// File: tb/tb_vga_csr_bank.sv
// tb_vga_csr_bank: directed self-checking bench for vga_csr_bank.
module tb_vga_csr_bank;
`ifdef VGA_CSR_FRAME_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        write_en = 1'b0;
    logic [3:0]  addr_write = '0;
    logic [31:0] wdata = '0;
    logic        read_en = 1'b0;
    logic [3:0]  addr_read = '0;
    logic [31:0] rdata;
    logic        frame_done = 1'b0;
    logic        enable;
    logic [11:0] bg_color;
    logic        irq;
    int          n_cmp = 0;
    int          n_bad = 0;
    int          exp_cnt = 0;
    logic [31:0] d;

    vga_csr_bank #(.ADDR_W(4), .DATA_W(32)) dut (
        .clk_i(clk), .arst_i(arst), .write_en_i(write_en), .addr_write_i(addr_write),
        .wdata_i(wdata), .read_en_i(read_en), .addr_read_i(addr_read), .rdata_o(rdata),
        .frame_done_i(frame_done), .enable_o(enable), .bg_color_o(bg_color), .irq_o(irq)
    );

    always #5 clk = ~clk;

    task automatic wr(input logic [3:0] a, input logic [31:0] v);
        @(negedge clk);
        write_en = 1'b1; addr_write = a; wdata = v;
        @(negedge clk);
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [31:0] v);
        @(negedge clk);
        read_en = 1'b1; addr_read = a;
        @(negedge clk);
        read_en = 1'b0;
        v = rdata;
    endtask

    task automatic pulse();
        @(negedge clk);
        frame_done = 1'b1;
        @(negedge clk);
        frame_done = 1'b0;
        if (enable) exp_cnt++;
    endtask

    task automatic test_reset();
        arst = 1'b1;
        repeat (3) @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL reset_rdata got %h want 0", rdata); end
        n_cmp++; if (enable !== 1'b0) begin n_bad++; $display("FAIL reset_enable got %b want 0", enable); end
        n_cmp++; if (bg_color !== 12'h0) begin n_bad++; $display("FAIL reset_bg got %h want 0", bg_color); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL reset_irq got %b want 0", irq); end
        for (int i = 0; i < 6; i++) begin
            rd(4'(i), d);
            n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL reset_read[%0d] got %h want 0", i, d); end
        end
    endtask

    task automatic test_rw();
        wr(4'h0, 32'hFFFF_FFFF);
        rd(4'h0, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL ctrl_read got %h want 3", d); end
        n_cmp++; if (enable !== 1'b1) begin n_bad++; $display("FAIL ctrl_enable got %b want 1", enable); end
        wr(4'h4, 32'hABCD_E123);
        rd(4'h4, d);
        n_cmp++; if (d !== 32'h123) begin n_bad++; $display("FAIL bg_read got %h want 123", d); end
        n_cmp++; if (bg_color !== 12'h123) begin n_bad++; $display("FAIL bg_out got %h want 123", bg_color); end
        wr(4'h5, 32'hDEAD_BEEF);
        rd(4'h5, d);
        n_cmp++; if (d !== 32'hDEAD_BEEF) begin n_bad++; $display("FAIL scratch_read got %h want deadbeef", d); end
    endtask

    task automatic test_frames();
        wr(4'h0, 32'h3);
        pulse();
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_early got %b want 0", irq); end
        @(negedge clk);
        n_cmp++; if (irq !== 1'b1) begin n_bad++; $display("FAIL irq_assert got %b want 1", irq); end
        repeat (4) pulse();
        rd(4'h3, d);
        n_cmp++; if (d !== (CNT_EN ? 32'd5 : 32'd0)) begin n_bad++; $display("FAIL frame_cnt got %h want %h", d, CNT_EN ? 32'd5 : 32'd0); end
        rd(4'h1, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL status got %h want 3", d); end
        wr(4'h2, 32'h1);
        @(negedge clk);
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_clear got %b want 0", irq); end
        rd(4'h2, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL irq_reg_clear got %h want 0", d); end
    endtask

    task automatic test_set_clear();
        wr(4'h0, 32'h1);
        @(negedge clk);
        write_en = 1'b1; addr_write = 4'h2; wdata = 32'h1; frame_done = 1'b1;
        @(negedge clk);
        write_en = 1'b0; frame_done = 1'b0;
        exp_cnt++;
        rd(4'h2, d);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL set_over_clear got %h want 1", d); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_masked got %b want 0", irq); end
    endtask

    task automatic test_back_to_back();
        wr(4'h5, 32'h1);
        @(negedge clk);
        write_en = 1'b1; addr_write = 4'h5; wdata = 32'h2; read_en = 1'b1; addr_read = 4'h5;
        @(negedge clk);
        write_en = 1'b0; read_en = 1'b0;
        n_cmp++; if (rdata !== 32'h1) begin n_bad++; $display("FAIL rw_same_cycle got %h want 1", rdata); end
        @(negedge clk);
        read_en = 1'b1; addr_read = 4'h5;
        @(negedge clk);
        addr_read = 4'h4;
        n_cmp++; if (rdata !== 32'h2) begin n_bad++; $display("FAIL b2b_first got %h want 2", rdata); end
        @(negedge clk);
        read_en = 1'b0;
        n_cmp++; if (rdata !== 32'h123) begin n_bad++; $display("FAIL b2b_second got %h want 123", rdata); end
        repeat (2) @(negedge clk);
        n_cmp++; if (rdata !== 32'h123) begin n_bad++; $display("FAIL rdata_hold got %h want 123", rdata); end
    endtask

    task automatic test_unmapped();
        wr(4'h7, 32'h1234);
        rd(4'h7, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL unmapped got %h want 0", d); end
        wr(4'h1, 32'h0);
        rd(4'h1, d);
        n_cmp++; if (d !== 32'h3) begin n_bad++; $display("FAIL status_ro got %h want 3", d); end
        wr(4'h3, 32'h55);
        rd(4'h3, d);
        n_cmp++; if (d !== (CNT_EN ? 32'(exp_cnt) : 32'd0)) begin n_bad++; $display("FAIL cnt_ro got %h want %h", d, CNT_EN ? 32'(exp_cnt) : 32'd0); end
    endtask

    task automatic test_disabled();
        wr(4'h0, 32'h0);
        rd(4'h1, d);
        n_cmp++; if (d !== 32'h1) begin n_bad++; $display("FAIL pending_kept got %h want 1", d); end
        wr(4'h2, 32'h1);
        repeat (3) pulse();
        rd(4'h3, d);
        n_cmp++; if (d !== (CNT_EN ? 32'd6 : 32'd0)) begin n_bad++; $display("FAIL cnt_frozen got %h want %h", d, CNT_EN ? 32'd6 : 32'd0); end
        rd(4'h2, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL no_pending got %h want 0", d); end
        n_cmp++; if (irq !== 1'b0) begin n_bad++; $display("FAIL irq_disabled got %b want 0", irq); end
    endtask

    task automatic test_reset_mid();
        wr(4'h0, 32'h3);
        @(negedge clk);
        read_en = 1'b1; addr_read = 4'h5; arst = 1'b1;
        @(negedge clk);
        read_en = 1'b0; arst = 1'b0;
        @(negedge clk);
        n_cmp++; if (rdata !== 32'h0) begin n_bad++; $display("FAIL mid_reset_rdata got %h want 0", rdata); end
        n_cmp++; if (enable !== 1'b0 || bg_color !== 12'h0) begin n_bad++; $display("FAIL mid_reset_out got %b/%h want 0/0", enable, bg_color); end
        rd(4'h5, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_reset_scratch got %h want 0", d); end
        rd(4'h3, d);
        n_cmp++; if (d !== 32'h0) begin n_bad++; $display("FAIL mid_reset_cnt got %h want 0", d); end
    endtask

    initial begin
        test_reset();
        test_rw();
        test_frames();
        test_set_clear();
        test_back_to_back();
        test_unmapped();
        test_disabled();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
